// File: rtl/memory_arbiter.sv
// Serialises instruction-fetch and data requests onto a single RAM port.
// Data has priority; a starvation counter forces an instruction grant after STARVE_MAX data grants.
module memory_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       dreq;

    assign dreq      = dREN | dWEN;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        starve_d = iREN ? starve_q : 4'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;

        case (state_q)
            IDLE: begin
                if (dreq && (starve_q < STARVE_LIM)) state_d = DGRANT;
                else if (iREN)                       state_d = IGRANT;
                else if (dreq)                       state_d = DGRANT;
            end
            DGRANT: begin
                // Strobes follow the cache live, so a cancelled request drops them at once.
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = IDLE;
                    if (iREN && starve_q != 4'd15) starve_d = starve_q + 4'd1;
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait    = 1'b0;
                    iload    = ramload;
                    state_d  = IDLE;
                    starve_d = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, read, write, ERROR retry, abort and starvation contention.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_IGRANT = 2'd1, S_DGRANT = 2'd2;
    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

    memory_arbiter #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'h0; ramstate = R_FREE;

        // Reset values with requests present
        step();
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h10; iaddr = 32'h300; dstore = 32'h55;
        settle();
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_loads", iload | dload, 32'h0);
        iREN = 1'b0;
        step();
        nRST = 1'b1;

        // Reset mid-DGRANT while RAM is BUSY
        step();
        ramstate = R_BUSY;
        settle();
        chk("mid_state", 32'(dbg_state), 32'(S_DGRANT));
        chk("mid_ramREN", 32'(ramREN), 32'd1);
        iREN = 1'b1;
        nRST = 1'b0;
        settle();
        chk("mid_rst_ramREN", 32'(ramREN), 32'd0);
        chk("mid_rst_dwait", 32'(dwait), 32'd1);
        chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
        step();
        nRST = 1'b1; dREN = 1'b0;
        step();
        settle();
        chk("post_rst_state", 32'(dbg_state), 32'(S_IGRANT));
        chk("post_rst_ramaddr", ramaddr, 32'h300);
        iREN = 1'b0;
        settle();
        chk("iabort_ramREN", 32'(ramREN), 32'd0);
        step();
        ramstate = R_FREE;
        settle();
        chk("iabort_state", 32'(dbg_state), 32'(S_IDLE));

        // Single read, ACCESS three cycles after grant
        dREN = 1'b1; daddr = 32'h40;
        settle();
        chk("rd_idle_dwait", 32'(dwait), 32'd1);
        chk("rd_idle_ramREN", 32'(ramREN), 32'd0);
        step();
        ramstate = R_BUSY;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rd_busy_dwait", 32'(dwait), 32'd1);
            chk("rd_busy_ramREN", 32'(ramREN), 32'd1);
            chk("rd_busy_ramaddr", ramaddr, 32'h40);
            chk("rd_busy_iwait", 32'(iwait), 32'd1);
            chk("rd_busy_dload", dload, 32'h0);
            step();
        end
        ramstate = R_ACCESS; ramload = 32'hDEADBEEF;
        settle();
        chk("rd_done_dwait", 32'(dwait), 32'd0);
        chk("rd_done_dload", dload, 32'hDEADBEEF);
        chk("rd_done_iwait", 32'(iwait), 32'd1);
        chk("rd_done_iload", iload, 32'h0);
        step();
        dREN = 1'b0; ramstate = R_FREE;
        settle();
        chk("rd_after_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rd_after_dwait", 32'(dwait), 32'd1);
        chk("rd_after_dload", dload, 32'h0);

        // Write held until ACCESS
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
        step();
        ramstate = R_BUSY;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wr_ramWEN", 32'(ramWEN), 32'd1);
            chk("wr_ramREN", 32'(ramREN), 32'd0);
            chk("wr_ramaddr", ramaddr, 32'h80);
            chk("wr_ramstore", ramstore, 32'h12345678);
            chk("wr_dwait", 32'(dwait), 32'd1);
            step();
        end
        ramstate = R_ACCESS;
        settle();
        chk("wr_done_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_done_dwait", 32'(dwait), 32'd0);
        step();
        dWEN = 1'b0; ramstate = R_FREE;
        settle();
        chk("wr_after_dwait", 32'(dwait), 32'd1);
        chk("wr_after_ramWEN", 32'(ramWEN), 32'd0);

        // Instruction fetch through BUSY, ERROR, ERROR, ACCESS
        iREN = 1'b1; iaddr = 32'h200;
        step();
        for (int i = 0; i < 3; i++) begin
            ramstate = (i == 0) ? R_BUSY : R_ERROR;
            settle();
            chk("err_iwait", 32'(iwait), 32'd1);
            chk("err_ramREN", 32'(ramREN), 32'd1);
            chk("err_ramWEN", 32'(ramWEN), 32'd0);
            chk("err_ramaddr", ramaddr, 32'h200);
            chk("err_state", 32'(dbg_state), 32'(S_IGRANT));
            step();
        end
        ramstate = R_ACCESS; ramload = 32'hCAFEF00D;
        settle();
        chk("err_done_iwait", 32'(iwait), 32'd0);
        chk("err_done_iload", iload, 32'hCAFEF00D);
        chk("err_done_dwait", 32'(dwait), 32'd1);
        chk("err_done_dload", dload, 32'h0);
        step();
        iREN = 1'b0; ramstate = R_FREE;
        settle();
        chk("err_after_iload", iload, 32'h0);

        // Data abort while BUSY
        dREN = 1'b1; daddr = 32'h44;
        step();
        ramstate = R_BUSY;
        settle();
        chk("abort_pre_ramREN", 32'(ramREN), 32'd1);
        dREN = 1'b0;
        settle();
        chk("abort_ramREN", 32'(ramREN), 32'd0);
        chk("abort_dwait", 32'(dwait), 32'd1);
        step();
        settle();
        chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
        chk("abort_after_dwait", 32'(dwait), 32'd1);

        // Contention: expected order D,D,D,D,I,D,D,D,D,I with an IDLE bubble between grants
        ramstate = R_FREE;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h1000; daddr = 32'h2000;
        for (int g = 0; g < 10; g++) begin
            ramstate = R_FREE;
            settle();
            chk("cont_bubble_state", 32'(dbg_state), 32'(S_IDLE));
            chk("cont_bubble_waits", 32'({iwait, dwait}), 32'd3);
            step();
            ramstate = R_ACCESS; ramload = 32'hA000_0000 + 32'(g);
            settle();
            if (g == 4 || g == 9) begin
                chk("cont_grant_i", 32'(dbg_state), 32'(S_IGRANT));
                chk("cont_i_iwait", 32'(iwait), 32'd0);
                chk("cont_i_iload", iload, 32'hA000_0000 + 32'(g));
                chk("cont_i_ramaddr", ramaddr, 32'h1000);
            end else begin
                chk("cont_grant_d", 32'(dbg_state), 32'(S_DGRANT));
                chk("cont_d_dwait", 32'(dwait), 32'd0);
                chk("cont_d_dload", dload, 32'hA000_0000 + 32'(g));
                chk("cont_d_ramaddr", ramaddr, 32'h2000);
            end
            step();
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = R_FREE;
        settle();
        chk("final_state", 32'(dbg_state), 32'(S_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
